// File: rtl/sdram_port_arbiter.sv
// Two-requester round-robin arbiter sharing one Avalon-MM master into SDRAM.
// Tracks the owner of every outstanding pipelined read so returned data is steered back.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [ADDR_W-1:0]           r0_address,
  input  logic                        r0_read,
  input  logic                        r0_write,
  input  logic [DATA_W-1:0]           r0_writedata,
  input  logic [DATA_W/8-1:0]         r0_byteenable,
  output logic                        r0_waitrequest,
  output logic [DATA_W-1:0]           r0_readdata,
  output logic                        r0_readdatavalid,
  input  logic [ADDR_W-1:0]           r1_address,
  input  logic                        r1_read,
  input  logic                        r1_write,
  input  logic [DATA_W-1:0]           r1_writedata,
  input  logic [DATA_W/8-1:0]         r1_byteenable,
  output logic                        r1_waitrequest,
  output logic [DATA_W-1:0]           r1_readdata,
  output logic                        r1_readdatavalid,
  output logic [ADDR_W-1:0]           m_address,
  output logic                        m_read,
  output logic                        m_write,
  output logic [DATA_W-1:0]           m_writedata,
  output logic [DATA_W/8-1:0]         m_byteenable,
  input  logic                        m_waitrequest,
  input  logic [DATA_W-1:0]           m_readdata,
  input  logic                        m_readdatavalid,
  output logic [$clog2(MAX_PEND):0]   pend_count,
  output logic                        err_unexpected
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic             owner;
  logic             prio;      // requester favoured on the next tie
  logic             id_mem [MAX_PEND];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic fifo_full, fifo_nonempty;
  logic elig0, elig1;
  logic busy, own_read, own_write;
  logic accept, push, pop, head;

  assign fifo_full     = (pend_count == CNT_W'(MAX_PEND));
  assign fifo_nonempty = (pend_count != '0);

  // Read+write together counts as a read, so it must respect the full check.
  assign elig0 = r0_read ? !fifo_full : r0_write;
  assign elig1 = r1_read ? !fifo_full : r1_write;

  assign busy      = (state == ST_BUSY);
  assign own_read  = owner ? r1_read  : r0_read;
  assign own_write = owner ? r1_write : r0_write;

  assign m_read       = busy & own_read;
  assign m_write      = busy & own_write & ~own_read;
  assign m_address    = owner ? r1_address    : r0_address;
  assign m_writedata  = owner ? r1_writedata  : r0_writedata;
  assign m_byteenable = owner ? r1_byteenable : r0_byteenable;

  assign accept = busy & ~m_waitrequest;
  assign push   = accept & own_read;
  assign pop    = m_readdatavalid & fifo_nonempty;
  assign head   = id_mem[rd_ptr];

  assign r0_waitrequest   = ~(accept & ~owner);
  assign r1_waitrequest   = ~(accept & owner);
  assign r0_readdatavalid = pop & ~head;
  assign r1_readdatavalid = pop & head;
  assign r0_readdata      = m_readdata;
  assign r1_readdata      = m_readdata;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (elig0 | elig1) begin
        state <= ST_BUSY;
        owner <= (elig0 & elig1) ? prio : elig1;
      end
    end else if (!m_waitrequest) begin
      state <= ST_IDLE;
      prio  <= ~owner;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pend_count     <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      pend_count <= pend_count + CNT_W'(push) - CNT_W'(pop);
      if (m_readdatavalid && !fifo_nonempty) err_unexpected <= 1'b1;
    end
  end

  // NOTE: the ID storage is not reset; entries are only read between push and pop,
  // so the pointers and pend_count alone define validity.
  always_ff @(posedge Clk) begin
    if (push) id_mem[wr_ptr] <= owner;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus a randomized run
// checked against a queue-based transaction model.
module tb_sdram_port_arbiter;
  localparam int ADDR_W   = 27;
  localparam int DATA_W   = 32;
  localparam int MAX_PEND = 4;
  localparam int BE_W     = DATA_W / 8;
  localparam int CNT_W    = $clog2(MAX_PEND) + 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] r0_address, r1_address, m_address;
  logic              r0_read, r0_write, r1_read, r1_write;
  logic [DATA_W-1:0] r0_writedata, r1_writedata, m_writedata;
  logic [BE_W-1:0]   r0_byteenable, r1_byteenable, m_byteenable;
  logic              r0_waitrequest, r1_waitrequest;
  logic [DATA_W-1:0] r0_readdata, r1_readdata, m_readdata;
  logic              r0_readdatavalid, r1_readdatavalid;
  logic              m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [CNT_W-1:0]  pend_count;
  logic              err_unexpected;

  int total = 0;
  int bad   = 0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .Clk(Clk), .Reset(Reset),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
    .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
    .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .pend_count(pend_count), .err_unexpected(err_unexpected)
  );

  always #5 Clk = ~Clk;

  // Transaction model: which requester holds the bus (-1 = none), who wins
  // the next tie, and the queue of read owners awaiting data.
  int  mdl_grant;
  bit  mdl_fav;
  bit  mdl_q[$];
  bit  mdl_err;

  logic              exp_mread, exp_mwrite, exp_wait0, exp_wait1, exp_rv0, exp_rv1, exp_err;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wdata;
  logic [BE_W-1:0]   exp_be;
  int                exp_pend;

  task automatic model_reset();
    mdl_grant = -1;
    mdl_fav   = 1'b0;
    mdl_q.delete();
    mdl_err   = 1'b0;
  endtask

  task automatic model_eval();
    exp_mread  = 1'b0;
    exp_mwrite = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_be     = '0;
    if (mdl_grant == 0) begin
      exp_mread = r0_read; exp_mwrite = r0_write & ~r0_read;
      exp_addr = r0_address; exp_wdata = r0_writedata; exp_be = r0_byteenable;
    end else if (mdl_grant == 1) begin
      exp_mread = r1_read; exp_mwrite = r1_write & ~r1_read;
      exp_addr = r1_address; exp_wdata = r1_writedata; exp_be = r1_byteenable;
    end
    exp_wait0 = !(mdl_grant == 0 && !m_waitrequest);
    exp_wait1 = !(mdl_grant == 1 && !m_waitrequest);
    exp_rv0   = m_readdatavalid && mdl_q.size() > 0 && mdl_q[0] == 1'b0;
    exp_rv1   = m_readdatavalid && mdl_q.size() > 0 && mdl_q[0] == 1'b1;
    exp_pend  = mdl_q.size();
    exp_err   = mdl_err;
  endtask

  task automatic model_commit();
    bit rd[2], wr[2], el[2];
    bit pop, push, pushed;
    rd[0] = r0_read; wr[0] = r0_write;
    rd[1] = r1_read; wr[1] = r1_write;
    pop    = m_readdatavalid && mdl_q.size() > 0;
    push   = 1'b0;
    pushed = 1'b0;
    if (m_readdatavalid && mdl_q.size() == 0) mdl_err = 1'b1;
    if (mdl_grant < 0) begin
      for (int n = 0; n < 2; n++) el[n] = rd[n] ? (mdl_q.size() < MAX_PEND) : wr[n];
      if (el[0] && el[1]) mdl_grant = int'(mdl_fav);
      else if (el[0])     mdl_grant = 0;
      else if (el[1])     mdl_grant = 1;
    end else if (!m_waitrequest) begin
      push      = rd[mdl_grant];
      pushed    = (mdl_grant == 1);
      mdl_fav   = (mdl_grant == 0);
      mdl_grant = -1;
    end
    if (pop)  void'(mdl_q.pop_front());
    if (push) mdl_q.push_back(pushed);
  endtask

  task automatic clear_inputs();
    r0_address = '0; r0_read = 0; r0_write = 0; r0_writedata = '0; r0_byteenable = '0;
    r1_address = '0; r1_read = 0; r1_write = 0; r1_writedata = '0; r1_byteenable = '0;
    m_waitrequest = 0; m_readdata = '0; m_readdatavalid = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    clear_inputs();
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    clear_inputs();
    r0_write = 1; m_readdatavalid = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if ({m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid} !== 6'b001100) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: got %b want 001100", c,
                 {m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid});
      end
      total++;
      if ({pend_count, err_unexpected} !== {CNT_W'(0), 1'b0}) begin
        bad++;
        $display("FAIL reset_state[%0d]: pend=%0d err=%b want 0/0", c, pend_count, err_unexpected);
      end
      @(negedge Clk);
    end
    Reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_write();
    do_reset();
    r0_address = 27'h100; r0_writedata = 32'hDEADBEEF; r0_byteenable = 4'hF;
    r0_write = 1; m_waitrequest = 0;
    #1;
    total++;
    if ({m_write, r0_waitrequest} !== 2'b01) begin
      bad++; $display("FAIL wr_cycle1: m_write/wait got %b want 01", {m_write, r0_waitrequest});
    end
    @(negedge Clk); #1;
    total++;
    if ({m_read, m_write, r0_waitrequest, r1_waitrequest} !== 4'b0101) begin
      bad++; $display("FAIL wr_cycle2: rd/wr/w0/w1 got %b want 0101", {m_read, m_write, r0_waitrequest, r1_waitrequest});
    end
    total++;
    if ({m_address, m_writedata, m_byteenable} !== {27'h100, 32'hDEADBEEF, 4'hF}) begin
      bad++; $display("FAIL wr_payload: got %h/%h/%h want 100/deadbeef/f", m_address, m_writedata, m_byteenable);
    end
    @(negedge Clk);
    r0_write = 0;
    #1;
    total++;
    if ({m_write, r0_waitrequest, pend_count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      bad++; $display("FAIL wr_cycle3: m_write=%b wait=%b pend=%0d want 0/1/0", m_write, r0_waitrequest, pend_count);
    end
  endtask

  task automatic test_back_to_back();
    int seq[$];
    do_reset();
    r0_address = 27'h10; r1_address = 27'h20;
    r0_write = 1; r1_write = 1; m_waitrequest = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!r0_waitrequest) begin
        seq.push_back(0);
        total++;
        if (m_address !== 27'h10 || !r1_waitrequest) begin
          bad++; $display("FAIL b2b_r0_accept: addr=%h w1=%b want 10/1", m_address, r1_waitrequest);
        end
      end
      if (!r1_waitrequest) begin
        seq.push_back(1);
        total++;
        if (m_address !== 27'h20 || !r0_waitrequest) begin
          bad++; $display("FAIL b2b_r1_accept: addr=%h w0=%b want 20/1", m_address, r0_waitrequest);
        end
      end
      @(negedge Clk);
    end
    total++;
    if (seq.size() != 4) begin
      bad++; $display("FAIL b2b_count: got %0d accepts want 4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (seq[i] != (i % 2)) begin
          bad++; $display("FAIL b2b_order[%0d]: got r%0d want r%0d", i, seq[i], i % 2);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_read_stall();
    do_reset();
    r0_address = 27'h200; r0_read = 1; r1_write = 1; r1_address = 27'h300;
    m_waitrequest = 1;
    #1;
    total++;
    if (m_read !== 1'b0) begin
      bad++; $display("FAIL stall_idle: m_read got %b want 0", m_read);
    end
    @(negedge Clk);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) m_waitrequest = 0;
      #1;
      total++;
      if ({m_read, m_write, m_address} !== {2'b10, 27'h200}) begin
        bad++; $display("FAIL stall_cmd[%0d]: rd=%b wr=%b addr=%h want 1/0/200", c, m_read, m_write, m_address);
      end
      total++;
      if ({r0_waitrequest, r1_waitrequest} !== {(c != 3), 1'b1}) begin
        bad++; $display("FAIL stall_wait[%0d]: w0w1 got %b want %b", c, {r0_waitrequest, r1_waitrequest}, {(c != 3), 1'b1});
      end
      @(negedge Clk);
    end
    r0_read = 0;
    #1;
    total++;
    if (pend_count !== CNT_W'(1)) begin
      bad++; $display("FAIL stall_pend: got %0d want 1", pend_count);
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    r1_address = 27'h300; r1_read = 1; m_waitrequest = 0;
    repeat (8) @(negedge Clk);
    r1_read = 0; r0_read = 1; r0_address = 27'h400;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if ({m_read, r0_waitrequest, pend_count} !== {1'b0, 1'b1, CNT_W'(MAX_PEND)}) begin
        bad++; $display("FAIL full_hold[%0d]: m_read=%b w0=%b pend=%0d want 0/1/%0d", c, m_read, r0_waitrequest, pend_count, MAX_PEND);
      end
      @(negedge Clk);
    end
    m_readdatavalid = 1; m_readdata = 32'hA5A5_0001;
    #1;
    total++;
    if ({r0_readdatavalid, r1_readdatavalid, r1_readdata} !== {2'b01, 32'hA5A5_0001}) begin
      bad++; $display("FAIL full_return: rv0=%b rv1=%b data=%h want 0/1/a5a50001", r0_readdatavalid, r1_readdatavalid, r1_readdata);
    end
    @(negedge Clk);
    m_readdatavalid = 0;
    #1;
    total++;
    if ({m_read, pend_count} !== {1'b0, CNT_W'(MAX_PEND - 1)}) begin
      bad++; $display("FAIL full_regrant: m_read=%b pend=%0d want 0/%0d", m_read, pend_count, MAX_PEND - 1);
    end
    @(negedge Clk); #1;
    total++;
    if ({m_read, m_address, r0_waitrequest} !== {1'b1, 27'h400, 1'b0}) begin
      bad++; $display("FAIL full_grant: m_read=%b addr=%h w0=%b want 1/400/0", m_read, m_address, r0_waitrequest);
    end
    @(negedge Clk);
    r0_read = 0;
    #1;
    total++;
    if (pend_count !== CNT_W'(MAX_PEND)) begin
      bad++; $display("FAIL full_refill: pend=%0d want %0d", pend_count, MAX_PEND);
    end
    clear_inputs();
  endtask

  task automatic test_interleave();
    bit          r0_tab[9]  = '{1, 1, 0, 0, 1, 1, 0, 0, 0};
    bit          r1_tab[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    bit          rdv_tab[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    logic [31:0] dat_tab[9] = '{0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, 0};
    logic [1:0]  rv_tab[9]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    int          pend_tab[9] = '{0, 0, 1, 1, 2, 2, 2, 1, 0};
    do_reset();
    r0_address = 27'h500; r1_address = 27'h600;
    for (int c = 0; c < 9; c++) begin
      r0_read = r0_tab[c]; r1_read = r1_tab[c];
      m_readdatavalid = rdv_tab[c]; m_readdata = dat_tab[c];
      #1;
      total++;
      if ({r0_readdatavalid, r1_readdatavalid} !== rv_tab[c]) begin
        bad++; $display("FAIL ilv_rv[%0d]: got %b want %b", c, {r0_readdatavalid, r1_readdatavalid}, rv_tab[c]);
      end
      total++;
      if (pend_count !== CNT_W'(pend_tab[c])) begin
        bad++; $display("FAIL ilv_pend[%0d]: got %0d want %0d", c, pend_count, pend_tab[c]);
      end
      if (rdv_tab[c]) begin
        total++;
        if ((r0_tab[c] ? r0_readdata : r1_readdata) !== dat_tab[c] && rv_tab[c][1] ? r0_readdata !== dat_tab[c] : r1_readdata !== dat_tab[c]) begin
          bad++; $display("FAIL ilv_data[%0d]: r0=%h r1=%h want %h", c, r0_readdata, r1_readdata, dat_tab[c]);
        end
      end
      @(negedge Clk);
    end
    #1;
    total++;
    if (err_unexpected !== 1'b0) begin
      bad++; $display("FAIL ilv_err: got %b want 0", err_unexpected);
    end
    clear_inputs();
  endtask

  task automatic test_reset_abort();
    do_reset();
    r0_address = 27'h700; r0_read = 1;
    for (int c = 0; c < 6; c++) begin
      m_waitrequest = (c >= 4);
      if (c < 5) @(negedge Clk);
    end
    #1;
    total++;
    if ({m_read, pend_count} !== {1'b1, CNT_W'(2)}) begin
      bad++; $display("FAIL abort_pre: m_read=%b pend=%0d want 1/2", m_read, pend_count);
    end
    Reset = 1;
    #1;
    total++;
    if ({m_read, r0_waitrequest, pend_count} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      bad++; $display("FAIL abort_reset: m_read=%b w0=%b pend=%0d want 0/1/0", m_read, r0_waitrequest, pend_count);
    end
    @(negedge Clk);
    Reset = 0; r0_read = 0; m_waitrequest = 0;
    m_readdatavalid = 1; m_readdata = 32'h77;
    #1;
    total++;
    if ({r0_readdatavalid, r1_readdatavalid, err_unexpected} !== 3'b000) begin
      bad++; $display("FAIL abort_rv: rv0/rv1/err got %b want 000", {r0_readdatavalid, r1_readdatavalid, err_unexpected});
    end
    @(negedge Clk);
    m_readdatavalid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if ({err_unexpected, pend_count} !== {1'b1, CNT_W'(0)}) begin
        bad++; $display("FAIL abort_sticky[%0d]: err=%b pend=%0d want 1/0", c, err_unexpected, pend_count);
      end
      @(negedge Clk);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit act[2], is_rd[2], is_wr[2], acc[2];
    int kind;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; acc[n] = 0; is_rd[n] = 0; is_wr[n] = 0;
    end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (act[n] && acc[n]) act[n] = 0;
        if (!act[n] && $urandom_range(0, 1) == 1) begin
          act[n]   = 1;
          kind     = $urandom_range(0, 15);
          is_rd[n] = (kind < 7) || (kind == 15);
          is_wr[n] = (kind >= 7);
          if (n == 0) begin
            r0_address = ADDR_W'($urandom); r0_writedata = $urandom; r0_byteenable = BE_W'($urandom);
          end else begin
            r1_address = ADDR_W'($urandom); r1_writedata = $urandom; r1_byteenable = BE_W'($urandom);
          end
        end
      end
      r0_read = act[0] & is_rd[0]; r0_write = act[0] & is_wr[0];
      r1_read = act[1] & is_rd[1]; r1_write = act[1] & is_wr[1];
      m_waitrequest   = ($urandom_range(0, 2) == 0);
      m_readdatavalid = (mdl_q.size() > 0) && ($urandom_range(0, 3) == 0);
      m_readdata      = $urandom;
      #1;
      model_eval();
      total++;
      if ({m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid} !==
          {exp_mread, exp_mwrite, exp_wait0, exp_wait1, exp_rv0, exp_rv1}) begin
        bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", cyc,
          {m_read, m_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid},
          {exp_mread, exp_mwrite, exp_wait0, exp_wait1, exp_rv0, exp_rv1});
      end
      if (exp_mread || exp_mwrite) begin
        total++;
        if (m_address !== exp_addr) begin
          bad++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, m_address, exp_addr);
        end
      end
      if (exp_mwrite) begin
        total++;
        if ({m_writedata, m_byteenable} !== {exp_wdata, exp_be}) begin
          bad++; $display("FAIL rnd_wdata@%0d: got %h/%h want %h/%h", cyc, m_writedata, m_byteenable, exp_wdata, exp_be);
        end
      end
      total++;
      if (r0_readdata !== m_readdata || r1_readdata !== m_readdata) begin
        bad++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h", cyc, r0_readdata, r1_readdata, m_readdata);
      end
      total++;
      if ({pend_count, err_unexpected} !== {CNT_W'(exp_pend), exp_err}) begin
        bad++; $display("FAIL rnd_state@%0d: pend=%0d err=%b want %0d/%b", cyc, pend_count, err_unexpected, exp_pend, exp_err);
      end
      acc[0] = !exp_wait0;
      acc[1] = !exp_wait1;
      model_commit();
      @(negedge Clk);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_stall();
    test_fifo_full();
    test_interleave();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one Avalon-MM master path into the SoC's SDRAM between two FPGA-fabric modules.
- Typical requesters are a VGA frame reader and a hardware accelerator, instantiated beside the Nios II system in the top level.
- Forwards one command at a time and holds it until downstream accept.
- Tracks the owner of each outstanding pipelined read in an ID FIFO, so every returned word is routed to the requester that issued the read.

Parameters:
ADDR_W, 27, byte-address width of requester and master ports
DATA_W, 32, data width; byteenable width is DATA_W/8
MAX_PEND, 4, maximum outstanding reads (ID FIFO depth, power of 2, >=2)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous active-high reset
r0_address / r1_address  in  ADDR_W  requester byte address
r0_read / r1_read  in  1  read request, held until waitrequest low
r0_write / r1_write  in  1  write request, held until waitrequest low
r0_writedata / r1_writedata  in  DATA_W  write data
r0_byteenable / r1_byteenable  in  DATA_W/8  byte lanes
r0_waitrequest / r1_waitrequest  out  1  low for exactly the accept cycle of that requester's command
r0_readdata / r1_readdata  out  DATA_W  returned read data (both driven from m_readdata)
r0_readdatavalid / r1_readdatavalid  out  1  read data valid for that requester
m_address  out  ADDR_W  to SDRAM slave
m_read, m_write  out  1  command strobes
m_writedata  out  DATA_W  write data
m_byteenable  out  DATA_W/8  byte lanes
m_waitrequest  in  1  slave stall
m_readdata  in  DATA_W  slave read data
m_readdatavalid  in  1  slave read data valid
pend_count  out  $clog2(MAX_PEND)+1  outstanding reads
err_unexpected  out  1  sticky: readdatavalid arrived with FIFO empty

Behaviour:
- Reset state:
  - FSM IDLE; owner=0; priority pointer favours r0.
  - FIFO empty; pend_count=0; err_unexpected=0.
  - m_read=m_write=0; rN_waitrequest=1; rN_readdatavalid=0.
  - Reset asserted mid-command aborts the command and discards all outstanding IDs. Any later m_readdatavalid is therefore unexpected and sets err_unexpected.
- Eligibility:
  - Requester N is eligible when rN_write=1.
  - Requester N is also eligible when rN_read=1 and the registered pend_count<MAX_PEND.
  - Read and write both high on one requester is illegal; the request is treated as a read.
- FSM IDLE:
  - m_read=m_write=0.
  - If exactly one requester is eligible: owner<=that requester, go BUSY.
  - If both are eligible: owner<=pointer, go BUSY.
  - If none is eligible: stay IDLE.
- FSM BUSY:
  - m_* driven combinationally from requester[owner].
  - r[owner]_waitrequest = m_waitrequest; the other requester's waitrequest=1.
  - On accept (m_waitrequest=0): go IDLE, pointer<=~owner. If the command was a read, push owner into the FIFO.
- Arbitration latency:
  - 1 cycle from request to m_* assertion.
  - Minimum 2 cycles per command (IDLE+BUSY).
  - Two continuously requesting masters alternate r0,r1,r0,...
- Read return:
  - m_readdatavalid pops the FIFO head.
  - rN_readdatavalid = m_readdatavalid & nonempty & (head==N), combinational, same cycle.
  - rN_readdata = m_readdata.
- Simultaneous push and pop: pend_count unchanged, FIFO pointers both advance.
- Pop with the FIFO empty: no pointer change, err_unexpected<=1 (cleared only by Reset).
- Pointer wrap: FIFO read/write pointers wrap modulo MAX_PEND; full/empty are decided from pend_count.
- Full FIFO:
  - Reads are held off in IDLE; writes still arbitrate.
  - A read already in BUSY was checked at grant, so it is never dropped.
- A requester dropping its request while in BUSY is a protocol violation. The arbiter keeps owner and waits for accept.

Test Plan:
- Reset, then r0 write addr 0x100 data 0xDEADBEEF, m_waitrequest low -> m_write=1 on cycle 2 with matching address/data; r0_waitrequest low that cycle only; pend_count stays 0.
- Both requesters issue continuous writes, m_waitrequest=0 -> commands granted in order r0,r1,r0,r1; neither requester starves.
- r0 read with m_waitrequest held high 3 cycles -> m_read held stable 4 cycles, r1 waitrequest=1 throughout; pend_count becomes 1 after accept.
- r1 issues 4 reads, r0 issues a 5th read with MAX_PEND=4 and no returns -> r0 read stalls in IDLE; the first m_readdatavalid pulses r1_readdatavalid; the next cycle r0 read is granted.
- Interleaved reads r0,r1,r0 with returns 0x11,0x22,0x33 -> r0_readdatavalid with 0x11, r1_readdatavalid with 0x22, r0_readdatavalid with 0x33; the return on the same cycle as a new read accept leaves pend_count unchanged.
- Reset asserted with 2 reads outstanding, then m_readdatavalid pulsed -> no rN_readdatavalid, err_unexpected=1 and stays 1.
